// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the second-generation system controller.
// Command bytes, error codes and the ALU operand register addresses live here.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_DATA,
    S_R_ADDR,
    S_R_SEND,
    S_B_ADDR,
    S_B_CNT,
    S_B_RD,
    S_B_SEND,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_ALU_SEND
  } state_e;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU    = 8'hDD;
  localparam logic [7:0] CMD_BURST  = 8'hEE;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CMD  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  // States that wait for the next frame byte and are therefore subject to the timeout
  function automatic logic is_timed(input state_e s);
    case (s)
      S_W_ADDR, S_W_DATA, S_R_ADDR, S_B_ADDR, S_B_CNT,
      S_ALU_A, S_ALU_B, S_ALU_FUN: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sys_ctrl_tmo.sv
// Inter-byte timeout counter: counts cycles while enabled, cleared by clr or
// when disabled; expired flags the cycle in which the count equals TMO_CYC.
module sys_ctrl_tmo #(
  parameter int TMO_CYC = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TMO_CYC);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clr || !en) begin
      cnt_q <= '0;
    end else if (cnt_q != LIM) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A zero limit turns the timeout off entirely
  assign expired = (TMO_CYC != 0) && en && (cnt_q == LIM);

endmodule

// File: rtl/sys_ctrl_mb.sv
// Command-frame decoder driving the register file, the clock-gated ALU and the
// TX FIFO. Strobes are decoded from state and inputs; error outputs are registered.
module sys_ctrl_mb
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WD       = 8,
  parameter int REG_ADDR_WD   = 4,
  parameter int ALU_FUN_WD    = 4,
  parameter int ALU_OUT_BYTES = 2,
  parameter int TMO_CYC       = 1023,
  localparam int ALU_OUT_WD   = DATA_WD * ALU_OUT_BYTES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WD-1:0]     DATA_SYNC,
  input  logic                   VALID_SYNC,
  input  logic [DATA_WD-1:0]     REG_RD_D,
  input  logic [ALU_OUT_WD-1:0]  ALU_OUT,
  input  logic                   ALU_OUT_VALID,
  input  logic                   FIFO_FULL,
  output logic                   REG_WR_EN,
  output logic                   REG_RD_EN,
  output logic [REG_ADDR_WD-1:0] REG_ADDR,
  output logic [DATA_WD-1:0]     REG_WR_D,
  output logic                   ALU_EN,
  output logic [ALU_FUN_WD-1:0]  ALU_FUN,
  output logic                   GATE_EN,
  output logic                   FIFO_WR_INC,
  output logic [DATA_WD-1:0]     FIFO_WR_D,
  output logic                   ERR_PULSE,
  output logic [1:0]             ERR_CODE
);

  // Result buffer is always four bytes wide so the byte index never selects past its end
  localparam int         BUF_WD   = 4 * DATA_WD;
  localparam logic [1:0] LAST_IDX = 2'(ALU_OUT_BYTES - 1);

  state_e                 state_q, state_d;
  logic [REG_ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0]     cnt_q, cnt_d;
  logic [ALU_FUN_WD-1:0]  fun_q, fun_d;
  logic [1:0]             idx_q, idx_d;
  logic [BUF_WD-1:0]      alu_q, alu_d;
  logic                   err_pulse_q, err_set;
  logic [1:0]             err_code_q, err_new;
  logic                   tmo_exp;

  sys_ctrl_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (VALID_SYNC),
    .en      (is_timed(state_q)),
    .expired (tmo_exp)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      fun_q       <= '0;
      idx_q       <= '0;
      alu_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      fun_q       <= fun_d;
      idx_q       <= idx_d;
      alu_q       <= alu_d;
      err_pulse_q <= err_set;
      if (err_set) err_code_q <= err_new;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    fun_d       = fun_q;
    idx_d       = idx_q;
    alu_d       = alu_q;
    err_set     = 1'b0;
    err_new     = ERR_NONE;
    REG_WR_EN   = 1'b0;
    REG_RD_EN   = 1'b0;
    REG_ADDR    = '0;
    REG_WR_D    = '0;
    ALU_EN      = 1'b0;
    ALU_FUN     = '0;
    GATE_EN     = 1'b0;
    FIFO_WR_INC = 1'b0;
    FIFO_WR_D   = '0;

    case (state_q)
      S_IDLE: begin
        if (VALID_SYNC) begin
          case (DATA_SYNC)
            DATA_WD'(CMD_WR):     state_d = S_W_ADDR;
            DATA_WD'(CMD_RD):     state_d = S_R_ADDR;
            DATA_WD'(CMD_ALU_OP): state_d = S_ALU_A;
            DATA_WD'(CMD_ALU):    state_d = S_ALU_FUN;
            DATA_WD'(CMD_BURST):  state_d = S_B_ADDR;
            default: begin
              err_set = 1'b1;
              err_new = ERR_CMD;
            end
          endcase
        end
      end
      S_W_ADDR: begin
        if (VALID_SYNC) begin
          addr_d  = DATA_SYNC[REG_ADDR_WD-1:0];
          state_d = S_W_DATA;
        end
      end
      S_W_DATA: begin
        if (VALID_SYNC) begin
          REG_WR_EN = 1'b1;
          REG_ADDR  = addr_q;
          REG_WR_D  = DATA_SYNC;
          state_d   = S_IDLE;
        end
      end
      S_R_ADDR: begin
        if (VALID_SYNC) begin
          REG_RD_EN = 1'b1;
          REG_ADDR  = DATA_SYNC[REG_ADDR_WD-1:0];
          state_d   = S_R_SEND;
        end
      end
      S_R_SEND: begin
        if (!FIFO_FULL) begin
          FIFO_WR_INC = 1'b1;
          FIFO_WR_D   = REG_RD_D;
          state_d     = S_IDLE;
        end
      end
      S_B_ADDR: begin
        if (VALID_SYNC) begin
          addr_d  = DATA_SYNC[REG_ADDR_WD-1:0];
          state_d = S_B_CNT;
        end
      end
      S_B_CNT: begin
        if (VALID_SYNC) begin
          cnt_d   = DATA_SYNC;
          state_d = (DATA_SYNC == '0) ? S_IDLE : S_B_RD;
        end
      end
      S_B_RD: begin
        REG_RD_EN = 1'b1;
        REG_ADDR  = addr_q;
        state_d   = S_B_SEND;
      end
      S_B_SEND: begin
        if (!FIFO_FULL) begin
          FIFO_WR_INC = 1'b1;
          FIFO_WR_D   = REG_RD_D;
          addr_d      = addr_q + REG_ADDR_WD'(1);
          cnt_d       = cnt_q - DATA_WD'(1);
          state_d     = (cnt_q == DATA_WD'(1)) ? S_IDLE : S_B_RD;
        end
      end
      S_ALU_A: begin
        if (VALID_SYNC) begin
          REG_WR_EN = 1'b1;
          REG_ADDR  = REG_ADDR_WD'(ALU_A_ADDR);
          REG_WR_D  = DATA_SYNC;
          state_d   = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (VALID_SYNC) begin
          REG_WR_EN = 1'b1;
          REG_ADDR  = REG_ADDR_WD'(ALU_B_ADDR);
          REG_WR_D  = DATA_SYNC;
          state_d   = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (VALID_SYNC) begin
          fun_d   = DATA_SYNC[ALU_FUN_WD-1:0];
          ALU_EN  = 1'b1;
          GATE_EN = 1'b1;
          ALU_FUN = DATA_SYNC[ALU_FUN_WD-1:0];
          state_d = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        ALU_EN  = 1'b1;
        GATE_EN = 1'b1;
        ALU_FUN = fun_q;
        if (ALU_OUT_VALID) begin
          alu_d   = BUF_WD'(ALU_OUT);
          idx_d   = '0;
          state_d = S_ALU_SEND;
        end
      end
      S_ALU_SEND: begin
        if (!FIFO_FULL) begin
          FIFO_WR_INC = 1'b1;
          FIFO_WR_D   = alu_q[int'(idx_q)*DATA_WD +: DATA_WD];
          idx_d       = idx_q + 2'd1;
          if (idx_q == LAST_IDX) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An arriving byte beats an expiry in the same cycle; otherwise abort the frame
    if (tmo_exp && !VALID_SYNC) begin
      state_d = S_IDLE;
      err_set = 1'b1;
      err_new = ERR_TMO;
    end
  end

  assign ERR_PULSE = err_pulse_q;
  assign ERR_CODE  = err_code_q;

endmodule
